seq_shift_add_multiplier: RTL and testbench
===========================================

# seq_shift_add_multiplier

Sequential unsigned shift-add multiplier with valid/ready handshakes on both operand input and product output. It is the responding end of the operand/product interface that the multiplier benches drive: it accepts an A/B pair, computes one partial product per cycle, and holds P until the consumer takes it. It is the area-minimal baseline point in the multiplier design-space sweep, alongside the combinational array variants.

## Interface

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair on A/B is valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- A  in  WIDTH  multiplicand, unsigned.
- B  in  WIDTH  multiplier, unsigned.
- out_valid  out  1  P holds a completed product.
- out_ready  in  1  consumer takes P.
- P  out  2*WIDTH  product A*B, unsigned, registered.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture A into mcand (zero-extended to 2*WIDTH), B into mplier, clear acc, load bit counter with WIDTH, go to BUSY.
- BUSY, one step per cycle:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, counter -= 1.
  - When the counter reaches 0 after the step: P <= acc (final value), go to DONE.
- DONE:
  - out_valid=1; P is held stable.
  - On out_ready: go to IDLE.
  - No operand accept occurs in the same cycle, because in_ready is low in DONE.
- A/B changes after acceptance are ignored.
- Arithmetic is full precision; no overflow is possible in 2*WIDTH bits. The accumulator is 2*WIDTH bits and the counter is $clog2(WIDTH+1) bits.
- Reset, in any state including mid-BUSY: the in-flight operation is discarded.
  - Next cycle: state=IDLE, in_ready=1, out_valid=0, P=0, acc=0.

## Timing

- Reset values: in_ready=1, out_valid=0, P=0.
- Latency without early termination: acceptance edge at cycle N gives out_valid=1 from cycle N+WIDTH+1. This is fixed and data-independent.
- Throughput: one product per WIDTH+2 cycles at best (accept, WIDTH BUSY cycles, one DONE cycle consumed by out_ready).
- out_valid stays high and P stays constant until the cycle out_ready is sampled high. out_valid is low the following cycle.
- in_ready and out_valid are never high together.
- in_ready is decoded from the state register only, with no combinational path from in_valid or out_ready.

## Configuration

- SEQ_MUL_EARLY_TERM_EN defined:
  - BUSY also exits when the shifted mplier becomes 0 after a step.
  - If B==0 at acceptance, the block goes from IDLE straight to DONE with P=0.
  - Latency is 1 cycle for B==0, otherwise msb_index(B)+2 cycles. Examples: B=1 gives 2; B=0x80 at WIDTH=8 gives 9.
  - Results are identical to the non-early-termination build.
- SEQ_MUL_EARLY_TERM_EN undefined: latency is always WIDTH+1; the zero-detect logic is not built.

## Structure

- Shared package mul_pkg holds:
  - the state enum typedef (IDLE/BUSY/DONE);
  - the default WIDTH constant;
  - a function for the product width (2*WIDTH).
- Sub-module seq_mul_dp holds the datapath: mcand/mplier shift registers, accumulator, counter and zero-detect.
  - Inputs: load, step.
  - Outputs: last, acc.
- The top level holds the FSM and handshake logic only.

## Test plan

All scenarios use WIDTH=8.

- **Basic product:** A=2, B=3 accepted at cycle 0 -> P=6 with out_valid=1 at cycle 9 without the macro, cycle 3 with it.
- **Maximum operands:** A=255, B=255 -> P=65025 (0xFE01); sweep all 2-bit products at WIDTH=2 -> P = A*B, latency 3.
- **Zero multiplier:** A=0xAB, B=0 -> P=0; with SEQ_MUL_EARLY_TERM_EN, out_valid at cycle 1.
- **Backpressure:** out_ready held low 5 cycles after out_valid -> P stays constant, in_ready stays 0; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- **Reset mid-operation:** rst pulsed in the 4th BUSY cycle -> the next cycle shows in_ready=1, out_valid=0, P=0; a new pair A=7, B=9 then yields P=63.
- **Back-to-back:** in_valid held high with three queued pairs (2×3, 3×2, 1×1) and out_ready tied high -> products 6, 6, 1 in order, each accept exactly one cycle after the prior out_valid.

Source files
------------

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// controller state encoding, default operand width, product-width helper.
package mul_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned prod_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product handshake bundle for seq_shift_add_multiplier.
// master = operand producer / product consumer, slave = the multiplier.
interface seq_shift_add_multiplier_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             A;
  logic [WIDTH-1:0]             B;
  logic                         out_valid;
  logic                         out_ready;
  logic [prod_width(WIDTH)-1:0] P;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P
  );

endinterface

// File: rtl/seq_shift_add_multiplier_dp.sv
// Datapath of the shift-add multiplier: multiplicand/multiplier shift
// registers, accumulator and bit counter. Optional zero-detect early exit
// is built only when SEQ_MUL_EARLY_TERM_EN is defined.
module seq_mul_dp
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic                         i_step,
  input  logic [WIDTH-1:0]             i_a,
  input  logic [WIDTH-1:0]             i_b,
  output logic                         o_last,
  output logic [prod_width(WIDTH)-1:0] o_acc
);

  localparam int unsigned PW = prod_width(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_acc_step;

  // Accumulator value after the current step (partial product added if mplier LSB set)
  always_comb begin
    w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  // Operand capture on load, one shift-add step per cycle while stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= {{(PW-WIDTH){1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (i_step) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // o_acc is the post-step (final on o_last) value so the controller can
  // register P in the same cycle instead of waiting for r_acc to settle.
  always_comb begin
    o_acc = i_load ? '0 : w_acc_step;
`ifdef SEQ_MUL_EARLY_TERM_EN
    o_last = (i_load && (i_b == '0)) ||
             (i_step && ((r_cnt == CW'(1)) || (r_mplier[WIDTH-1:1] == '0)));
`else
    o_last = i_step && (r_cnt == CW'(1));
`endif
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, valid/ready on operands and
// product. Controller FSM and handshake only; arithmetic in seq_mul_dp.
// Build option: SEQ_MUL_EARLY_TERM_EN enables zero-multiplier early exit.
module seq_shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int unsigned PW = prod_width(WIDTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_load;
  logic          w_step;
  logic          w_last;
  logic [PW-1:0] w_acc;
  logic [PW-1:0] r_p;

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (bus.A),
    .i_b    (bus.B),
    .o_last (w_last),
    .o_acc  (w_acc)
  );

  // Load/step strobes kept outside the next-state block to avoid a false loop through w_last
  assign w_load = (r_state == IDLE) && bus.in_valid;
  assign w_step = (r_state == BUSY);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = w_last ? DONE : BUSY;
      BUSY:    if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Product register, written once per operation and held through DONE
  always_ff @(posedge clk) begin
    if (rst)                         r_p <= '0;
    else if ((w_load || w_step) && w_last) r_p <= w_acc;
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.P         = r_p;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier: WIDTH=8 directed vectors
// plus an exhaustive WIDTH=2 sweep. Expected latency follows
// SEQ_MUL_EARLY_TERM_EN when defined.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  seq_shift_add_multiplier_if #(.WIDTH(8)) bus8 ();
  seq_shift_add_multiplier_if #(.WIDTH(2)) bus2 ();

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_shift_add_multiplier #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] p;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   bp_cycles  = 0;
  bit   mon_busy   = 1'b0;
  int   last_done8 = -100;

  function automatic int exp_lat(input logic [31:0] b, input int w);
    int r;
    r = w + 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
    if (b == 0) r = 1;
    else for (int i = 0; i < w; i++) if (b[i]) r = i + 2;
`endif
    return r;
  endfunction

  // Present an operand pair and wait for acceptance; expected result queued on accept.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input bit keep, input bit chk_b2b);
    int t;
    bus8.A = a; bus8.B = b; bus8.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus8.in_ready && t < 300) begin @(negedge clk); t++; end
    check("accept8", 32'(bus8.in_ready), 32'd1);
    if (!bus8.in_ready) begin bus8.in_valid = 1'b0; return; end
    if (chk_b2b) check("b2b_accept_cycle", 32'(cyc), 32'(last_done8 + 1));
    q8.push_back('{p: 32'(p), acc_cyc: cyc, lat: exp_lat(32'(b), 8)});
    @(posedge clk); #1;
    if (!keep) bus8.in_valid = 1'b0;
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input bit keep);
    int t;
    bus2.A = a; bus2.B = b; bus2.in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus2.in_ready && t < 50) begin @(negedge clk); t++; end
    check("accept2", 32'(bus2.in_ready), 32'd1);
    if (!bus2.in_ready) begin bus2.in_valid = 1'b0; return; end
    q2.push_back('{p: 32'(a) * 32'(b), acc_cyc: cyc, lat: exp_lat(32'(b), 2)});
    @(posedge clk); #1;
    if (!keep) bus2.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() != 0 || q2.size() != 0 || mon_busy || bus8.out_valid || bus2.out_valid)
           && t < 400) begin
      @(negedge clk); t++;
    end
    check("drain_complete", 32'(t < 400), 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor for WIDTH=8: compares products/latency, applies backpressure when requested
  initial begin
    exp_t        e;
    logic [15:0] hold;
    bus8.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && bus8.out_valid) begin
        mon_busy   = 1'b1;
        last_done8 = cyc;
        check("out8_expected", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check("P8", 32'(bus8.P), e.p);
          check("latency8", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
        hold = bus8.P;
        if (bp_cycles > 0) begin
          bus8.out_ready = 1'b0;
          for (int i = 0; i < bp_cycles; i++) begin
            @(negedge clk);
            check("bp_out_valid_held", 32'(bus8.out_valid), 32'd1);
            check("bp_P_stable", 32'(bus8.P), 32'(hold));
            check("bp_in_ready_low", 32'(bus8.in_ready), 32'd0);
          end
          bus8.out_ready = 1'b1;
        end
        @(negedge clk);
        check("post_take_out_valid", 32'(bus8.out_valid), 32'd0);
        check("post_take_in_ready", 32'(bus8.in_ready), 32'd1);
        mon_busy = 1'b0;
      end
    end
  end

  // Monitor for WIDTH=2: consumer always ready
  initial begin
    exp_t e;
    bus2.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && bus2.out_valid) begin
        check("out2_expected", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          check("P2", 32'(bus2.P), e.p);
          check("latency2", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
        @(negedge clk);
        check("post_take_out_valid2", 32'(bus2.out_valid), 32'd0);
      end
    end
  end

  // in_ready and out_valid must never be high together
  always @(negedge clk) begin
    if (!rst) begin
      check("excl8", 32'(bus8.in_ready & bus8.out_valid), 32'd0);
      check("excl2", 32'(bus2.in_ready & bus2.out_valid), 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence
  initial begin
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0;
    bus2.in_valid = 1'b0; bus2.A = '0; bus2.B = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_P", 32'(bus8.P), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue8(8'd2,   8'd3,   16'd6,     1'b0, 1'b0); drain();
    issue8(8'd255, 8'd255, 16'hFE01,  1'b0, 1'b0); drain();
    issue8(8'hAB,  8'd0,   16'd0,     1'b0, 1'b0); drain();

    bp_cycles = 5;
    issue8(8'h12,  8'h34,  16'h03A8,  1'b0, 1'b0); drain();
    bp_cycles = 0;

    issue8(8'h55,  8'hFF,  16'h54AB,  1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q8.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("midrst_P", 32'(bus8.P), 32'd0);
    @(posedge clk); #1;
    issue8(8'd7,   8'd9,   16'd63,    1'b0, 1'b0); drain();

    issue8(8'd2,   8'd3,   16'd6,     1'b1, 1'b0);
    issue8(8'd3,   8'd2,   16'd6,     1'b1, 1'b1);
    issue8(8'd1,   8'd1,   16'd1,     1'b0, 1'b1);
    drain();

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        issue2(2'(a), 2'(b), !(a == 3 && b == 3));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
